// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice plus a carry register,
// adding two WIDTH-bit operands LSB first over WIDTH cycles.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_a_q, shift_a_d;
  logic [WIDTH-1:0] shift_b_q, shift_b_d;
  logic [WIDTH-1:0] partial_q, partial_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [CW-1:0]    count_q, count_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             sum_bit;
  logic             carry_nxt;
  logic [WIDTH-1:0] partial_nxt;

  // The single full-adder slice.
  assign sum_bit     = shift_a_q[0] ^ shift_b_q[0] ^ carry_q;
  assign carry_nxt   = (shift_a_q[0] & shift_b_q[0]) |
                       (shift_a_q[0] & carry_q) |
                       (shift_b_q[0] & carry_q);
  assign partial_nxt = {sum_bit, partial_q[WIDTH-1:1]};

  always_comb begin
    state_d   = state_q;
    shift_a_d = shift_a_q;
    shift_b_d = shift_b_q;
    partial_d = partial_q;
    s_d       = s_q;
    count_d   = count_q;
    carry_d   = carry_q;
    cout_d    = cout_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          shift_a_d = a;
          shift_b_d = b;
          carry_d   = cin;
          count_d   = '0;
          partial_d = '0;
          state_d   = RUN;
        end
      end
      RUN: begin
        shift_a_d = shift_a_q >> 1;
        shift_b_d = shift_b_q >> 1;
        partial_d = partial_nxt;
        carry_d   = carry_nxt;
        count_d   = count_q + 1'b1;
        if (count_q == LAST) begin
          s_d     = partial_nxt;
          cout_d  = carry_nxt;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Status flags follow the next state so they come straight from flops.
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_a_q <= '0;
      shift_b_q <= '0;
      partial_q <= '0;
      s_q       <= '0;
      count_q   <= '0;
      carry_q   <= 1'b0;
      cout_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_a_q <= shift_a_d;
      shift_b_q <= shift_b_d;
      partial_q <= partial_d;
      s_q       <= s_d;
      count_q   <= count_d;
      carry_q   <= carry_d;
      cout_q    <= cout_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign s    = s_q;
  assign cout = cout_q;

endmodule
